shifter_iter: RTL and testbench

Parametrised, multi-cycle successor to the ALU's combinational shifter. It performs SLL, SRL, SRA, ROL and ROR on an XLEN-bit operand, consuming at most STEP bit positions per clock. This trades latency for area in low-cost core configurations. It sits beside the ALU with valid/ready handshakes on both the operand side and the result side, and uses the ALU's 5-bit instruction encoding.

---
 rtl/shifter_iter.sv | 202 ++++++++++++++++++++
 tb/tb_shifter_iter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/shifter_iter.sv
// shifter_iter: multi-cycle SLL/SRL/SRA/ROL/ROR unit for the ALU.
// The operand is shifted by at most STEP positions per clock until the
// requested amount (taken modulo XLEN) has been consumed. Operands arrive
// over a valid/ready handshake, and results leave over another one.
// The result is held in a register. out_valid qualifies that register.
module shifter_iter #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      Instruction_to_ALU,
  input  logic [XLEN-1:0] ALU_dat1,
  input  logic [XLEN-1:0] ALU_dat2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Shifter_out
);

  localparam int SHW = $clog2(XLEN);

  // The largest per-cycle amount that can ever occur. The remaining count
  // is always < XLEN, so when STEP == XLEN a step never exceeds XLEN-1.
  localparam int MAXK = (STEP < XLEN) ? STEP : (XLEN - 1);

  // STEP widened by one bit so that STEP == XLEN is still representable.
  localparam logic [SHW:0] STEP_W = (SHW + 1)'(STEP);

  // ALU opcode encodings accepted by this unit.
  localparam logic [4:0] OP_SLL = 5'd8;
  localparam logic [4:0] OP_SRL = 5'd12;
  localparam logic [4:0] OP_SRA = 5'd13;
  localparam logic [4:0] OP_ROL = 5'd14;
  localparam logic [4:0] OP_ROR = 5'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    K_SLL = 3'd0,
    K_SRL = 3'd1,
    K_SRA = 3'd2,
    K_ROL = 3'd3,
    K_ROR = 3'd4
  } kind_t;

  // Shift w by the elaboration-time constant k (0 < k < XLEN). Each call
  // is pure wiring. Only the selection between the amounts costs logic.
  function automatic logic [XLEN-1:0] shift_const(
    input kind_t           kind,
    input logic [XLEN-1:0] w,
    input int              k
  );
    logic [XLEN-1:0] res;
    case (kind)
      K_SLL:   res = w << k;
      K_SRL:   res = w >> k;
      K_SRA:   res = XLEN'($signed(w) >>> k);
      K_ROL:   res = (w << k) | (w >> (XLEN - k));
      K_ROR:   res = (w >> k) | (w << (XLEN - k));
      default: res = w;
    endcase
    return res;
  endfunction

  // Apply one step of amt positions (0..MAXK). This is a (MAXK+1)-way
  // select over constant shifts rather than a full barrel shifter.
  function automatic logic [XLEN-1:0] step_shift(
    input kind_t           kind,
    input logic [XLEN-1:0] w,
    input logic [SHW-1:0]  amt
  );
    logic [XLEN-1:0] res;
    res = w;
    for (int k = 1; k <= MAXK; k++) begin
      if (amt == SHW'(k)) begin
        res = shift_const(kind, w, k);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t          r_state;
  kind_t           r_kind;
  logic [XLEN-1:0] r_work;
  logic [SHW-1:0]  r_rem;
  logic            r_out_valid;
  logic [XLEN-1:0] r_result;

  kind_t           w_in_kind;
  logic            w_in_ok;
  logic [SHW-1:0]  w_in_amt;
  logic            w_rem_ge_step;
  logic [SHW-1:0]  w_amt;
  logic [SHW-1:0]  w_rem_next;
  logic [XLEN-1:0] w_work_step;
  logic            w_unused_dat2;

  // Only the low SHW bits of the amount matter. The rest are intentionally dropped.
  assign w_in_amt      = ALU_dat2[SHW-1:0];
  assign w_unused_dat2 = ^ALU_dat2[XLEN-1:SHW];

  // Decode the incoming opcode into a shift kind and a supported flag.
  always_comb begin
    w_in_kind = K_SLL;
    w_in_ok   = 1'b1;
    case (Instruction_to_ALU)
      OP_SLL:  w_in_kind = K_SLL;
      OP_SRL:  w_in_kind = K_SRL;
      OP_SRA:  w_in_kind = K_SRA;
      OP_ROL:  w_in_kind = K_ROL;
      OP_ROR:  w_in_kind = K_ROR;
      default: w_in_ok   = 1'b0;
    endcase
  end

  // Compute the amount and partial result for the current BUSY step.
  always_comb begin
    w_rem_ge_step = ({1'b0, r_rem} >= STEP_W);
    if (w_rem_ge_step) begin
      w_amt = STEP_W[SHW-1:0];
    end else begin
      w_amt = r_rem;
    end
    w_rem_next  = r_rem - w_amt;
    w_work_step = step_shift(r_kind, r_work, w_amt);
  end

  // Control FSM and datapath registers. Reset takes priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_kind      <= K_SLL;
      r_work      <= '0;
      r_rem       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_kind <= w_in_kind;
            r_rem  <= w_in_amt;
            if (!w_in_ok) begin
              // Unsupported opcodes complete immediately with a zero result.
              r_work      <= '0;
              r_result    <= '0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else if (w_in_amt == '0) begin
              r_work      <= ALU_dat1;
              r_result    <= ALU_dat1;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_work  <= ALU_dat1;
              r_state <= S_BUSY;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_work <= w_work_step;
          r_rem  <= w_rem_next;
          if (w_rem_next == '0) begin
            r_result    <= w_work_step;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_state <= S_BUSY;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // in_ready drops in the same cycle that rst rises, so it is gated by rst directly.
  assign in_ready    = (r_state == S_IDLE) && !rst;
  assign out_valid   = r_out_valid;
  assign Shifter_out = r_result;

endmodule

// File: tb/tb_shifter_iter.sv
// Self-checking bench for shifter_iter (XLEN=32, STEP=4): directed cases
// plus randomised operations checked against a one-shot arithmetic model.
module tb_shifter_iter;

  localparam int XLEN = 32;
  localparam int STEP = 4;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      Instruction_to_ALU;
  logic [XLEN-1:0] ALU_dat1;
  logic [XLEN-1:0] ALU_dat2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] Shifter_out;

  int n_checks = 0;
  int n_errors = 0;

  shifter_iter #(.XLEN(XLEN), .STEP(STEP)) dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .Instruction_to_ALU (Instruction_to_ALU),
    .ALU_dat1           (ALU_dat1),
    .ALU_dat2           (ALU_dat2),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .Shifter_out        (Shifter_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-shot reference built from plain arithmetic: a shift by n is a
  // multiplication or a division by 2**n, truncated to XLEN bits.
  function automatic logic [XLEN-1:0] ref_shift(input logic [4:0] op, input logic [XLEN-1:0] d1,
                                                input logic [XLEN-1:0] d2);
    logic [63:0] mask, v, p, r;
    int n;
    mask = (64'd1 << XLEN) - 64'd1;
    v    = {32'd0, d1};
    n    = int'(d2 % XLEN);
    p    = 64'd1 << n;
    case (op)
      5'd8:  r = (v * p) & mask;
      5'd12: r = v / p;
      5'd13: r = d1[XLEN-1] ? (mask ^ ((mask ^ v) / p)) : (v / p);
      5'd14: r = ((v * p) & mask) | (v / (64'd1 << (XLEN - n)));
      5'd15: r = (v / p) | ((v * (64'd1 << (XLEN - n))) & mask);
      default: r = 64'd0;
    endcase
    return r[XLEN-1:0];
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [XLEN-1:0] d2);
    int n;
    n = int'(d2 % XLEN);
    if (!(op == 5'd8 || op == 5'd12 || op == 5'd13 || op == 5'd14 || op == 5'd15) || n == 0)
      return 1;
    return (n + STEP - 1) / STEP + 1;
  endfunction

  // Issue one operation, wait for the result, hold out_ready low for some cycles, then consume.
  task automatic run_op(input logic [4:0] op, input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                        input int hold, input bit noise);
    int w;
    int cyc;
    logic [XLEN-1:0] exp_val;
    exp_val = ref_shift(op, d1, d2);
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check_eq("accept_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    Instruction_to_ALU = op;
    ALU_dat1 = d1;
    ALU_dat2 = d2;
    @(posedge clk); #1;
    cyc = 1;
    in_valid = 1'b0;
    while (!out_valid && cyc < 100) begin
      if (noise) begin
        in_valid = 1'b1;
        Instruction_to_ALU = 5'($urandom);
        ALU_dat1 = $urandom;
        ALU_dat2 = $urandom;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("latency", 64'(cyc), 64'(ref_latency(op, d2)));
    check_eq("result", {32'd0, Shifter_out}, {32'd0, exp_val});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", {63'd0, out_valid}, 64'd1);
      check_eq("hold_value", {32'd0, Shifter_out}, {32'd0, exp_val});
      check_eq("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("valid_drop", {63'd0, out_valid}, 64'd0);
    check_eq("ready_return", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [4:0] ops [5];
    int seen;
    ops[0] = 5'd8; ops[1] = 5'd12; ops[2] = 5'd13; ops[3] = 5'd14; ops[4] = 5'd15;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    Instruction_to_ALU = 5'd0;
    ALU_dat1 = '0;
    ALU_dat2 = '0;
    #1;
    check_eq("rst_in_ready_early", {63'd0, in_ready}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_out", {32'd0, Shifter_out}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed cases.
    run_op(5'd13, 32'h80000000, 32'd31, 0, 1'b0);
    check_eq("sra_31", {32'd0, ref_shift(5'd13, 32'h80000000, 32'd31)}, 64'hFFFFFFFF);
    run_op(5'd15, 32'h12345678, 32'd8, 1, 1'b0);
    run_op(5'd8, 32'h00000001, 32'h25, 0, 1'b0);
    run_op(5'd8, 32'h00000001, 32'd0, 0, 1'b0);
    run_op(5'd3, 32'hFFFFFFFF, 32'd7, 5, 1'b0);
    run_op(5'd14, 32'h80000001, 32'd1, 0, 1'b0);

    // Reset in the middle of a long operation discards it.
    in_valid = 1'b1;
    Instruction_to_ALU = 5'd13;
    ALU_dat1 = 32'h80000000;
    ALU_dat2 = 32'd31;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("midrst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("midrst_out", {32'd0, Shifter_out}, 64'd0);
    check_eq("midrst_ready", {63'd0, in_ready}, 64'd1);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("midrst_no_valid", 64'(seen), 64'd0);
    run_op(5'd12, 32'h000000F0, 32'd4, 0, 1'b0);

    // Exhaustive amounts for every op with random operands and upper amount bits.
    for (int o = 0; o < 5; o++) begin
      for (int n = 0; n < XLEN; n++) begin
        run_op(ops[o], $urandom, ($urandom & 32'hFFFFFFE0) | 32'(n),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end
    end

    // Fully random opcodes, including unsupported ones.
    for (int i = 0; i < 60; i++) begin
      run_op(5'($urandom), $urandom, $urandom, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
